// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image over 8N1 serial, writes it
// word by word into instruction RAM, then releases the core via fetch enable.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n_sync,
    input  logic                  uart_rx_input,
    input  logic                  boot_bypass_i,
    input  logic                  fetch_enable_input,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  fetch_enable_o,
    output logic                  loading_o,
    output logic                  boot_error_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [32:0] LEN_MAX = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        ST_SYNC, ST_LEN0, ST_LEN1, ST_LEN2, ST_LEN3,
        ST_DATA, ST_CSUM, ST_DONE, ST_ERROR
    } state_t;

    logic rx_meta, rx_sync, rx_prev;

    rx_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic half_tick, full_tick, bit_tick;
    logic byte_valid, frame_err;

    state_t state_q, state_d;
    logic loading;
    logic [23:0] len_lo_q;
    logic [ADDR_WIDTH:0] len_q;
    logic [ADDR_WIDTH:0] byte_cnt_q;
    logic [ADDR_WIDTH-3:0] word_idx_q;
    logic [7:0] csum_q;
    logic [31:0] word_q;
    logic [31:0] len_full;
    logic len_bad, last_byte;
    logic mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    // Synchronizer flops reset to the idle-high line level.
    always_ff @(posedge clock or negedge reset_n_sync) begin
        if (!reset_n_sync) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_input;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        half_tick  = (clk_cnt_q == HALF_M1);
        full_tick  = (clk_cnt_q == FULL_M1);
        bit_tick   = (rx_state_q == RX_DATA) && full_tick;
        if (boot_bypass_i) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE:  if (rx_prev && !rx_sync) rx_state_d = RX_START;
                RX_START: if (half_tick) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                RX_DATA:  if (full_tick && bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                RX_STOP: begin
                    if (full_tick) begin
                        rx_state_d = RX_IDLE;
                        byte_valid = rx_sync;
                        frame_err  = !rx_sync;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n_sync) begin
        if (!reset_n_sync) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            if (rx_state_d != rx_state_q || bit_tick || rx_state_q == RX_IDLE)
                clk_cnt_q <= '0;
            else
                clk_cnt_q <= clk_cnt_q + 1'b1;
            if (rx_state_q == RX_START) begin
                bit_idx_q <= '0;
            end else if (bit_tick) begin
                bit_idx_q <= bit_idx_q + 1'b1;
                shift_q   <= {rx_sync, shift_q[7:1]};
            end
        end
    end

    assign loading   = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_LEN2) ||
                       (state_q == ST_LEN3) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign len_full  = {shift_q, len_lo_q};
    assign len_bad   = (len_full == 32'd0) || (len_full[1:0] != 2'b00) ||
                       ({1'b0, len_full} > LEN_MAX);
    assign last_byte = ((byte_cnt_q + CNT_ONE) == len_q);

    always_comb begin
        state_d = state_q;
        if (boot_bypass_i && loading) begin
            state_d = ST_SYNC;
        end else if (frame_err && state_q != ST_DONE) begin
            state_d = ST_ERROR;
        end else if (byte_valid) begin
            case (state_q)
                ST_SYNC, ST_ERROR: if (shift_q == SYNC_BYTE) state_d = ST_LEN0;
                ST_LEN0: state_d = ST_LEN1;
                ST_LEN1: state_d = ST_LEN2;
                ST_LEN2: state_d = ST_LEN3;
                ST_LEN3: state_d = len_bad ? ST_ERROR : ST_DATA;
                ST_DATA: if (last_byte) state_d = ST_CSUM;
                ST_CSUM: state_d = (shift_q == csum_q) ? ST_DONE : ST_ERROR;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n_sync) begin
        if (!reset_n_sync) state_q <= ST_SYNC;
        else state_q <= state_d;
    end

    // Datapath: length capture, lane assembly, checksum and the one-cycle RAM write.
    always_ff @(posedge clock or negedge reset_n_sync) begin
        if (!reset_n_sync) begin
            len_lo_q    <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_req_q <= 1'b0;
            if (byte_valid) begin
                case (state_q)
                    ST_SYNC, ST_ERROR: begin
                        if (shift_q == SYNC_BYTE) begin
                            byte_cnt_q <= '0;
                            word_idx_q <= '0;
                            csum_q     <= '0;
                        end
                    end
                    ST_LEN0: len_lo_q[7:0]   <= shift_q;
                    ST_LEN1: len_lo_q[15:8]  <= shift_q;
                    ST_LEN2: len_lo_q[23:16] <= shift_q;
                    ST_LEN3: len_q <= len_full[ADDR_WIDTH:0];
                    ST_DATA: begin
                        word_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= shift_q;
                        csum_q     <= csum_q + shift_q;
                        byte_cnt_q <= byte_cnt_q + CNT_ONE;
                        if (byte_cnt_q[1:0] == 2'd3) begin
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {word_idx_q, 2'b00};
                            mem_wdata_q <= {shift_q, word_q[23:0]};
                            word_idx_q  <= word_idx_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_req_q;
    assign mem_be_o       = 4'hF;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign fetch_enable_o = boot_bypass_i ? fetch_enable_input : (state_q == ST_DONE);
    assign loading_o      = loading;
    assign boot_error_o   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: serial byte driver, byte-level
// protocol model with an expected-write queue, and a per-cycle write checker.
module tb_uart_boot_loader;
    localparam int CPB = 8;
    localparam int AW  = 8;
    localparam int W   = AW + 32;
    localparam int P_SYNC = 0, P_LEN = 1, P_DATA = 2, P_CSUM = 3, P_DONE = 4, P_ERR = 5;

    logic clock = 1'b0;
    logic reset_n_sync;
    logic uart_rx_input;
    logic boot_bypass_i;
    logic fetch_enable_input;
    logic mem_req_o, mem_we_o;
    logic [3:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic fetch_enable_o, loading_o, boot_error_o;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [7:0] pay_q[$];

    int m_phase, m_k, m_cnt;
    logic [31:0] m_len, m_word;
    logic [7:0] m_sum;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n_sync(reset_n_sync), .uart_rx_input(uart_rx_input),
        .boot_bypass_i(boot_bypass_i), .fetch_enable_input(fetch_enable_input),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .fetch_enable_o(fetch_enable_o), .loading_o(loading_o), .boot_error_o(boot_error_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Write checker: every strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset_n_sync && mem_req_o) begin
            got_q.push_back({mem_addr_o, mem_wdata_o});
            check("mem_we", {63'd0, mem_we_o}, 64'd1);
            check("mem_be", {60'd0, mem_be_o}, 64'hF);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write got=%0h want=none at %0t", {mem_addr_o, mem_wdata_o}, $time);
            end else begin
                check("mem_write", {24'd0, mem_addr_o, mem_wdata_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic model_reset();
        m_phase = P_SYNC; m_k = 0; m_cnt = 0; m_len = 0; m_word = 0; m_sum = 0;
        exp_q.delete();
    endtask

    // Protocol reference at byte granularity; predicts writes before the byte is sent.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            if (m_phase != P_DONE) m_phase = P_ERR;
            return;
        end
        case (m_phase)
            P_SYNC, P_ERR: if (b == 8'hA5) begin
                m_phase = P_LEN; m_k = 0; m_len = 0; m_cnt = 0; m_sum = 0; m_word = 0;
            end
            P_LEN: begin
                m_len = m_len | (32'(b) << (8 * m_k));
                m_k++;
                if (m_k == 4)
                    m_phase = (m_len == 0 || m_len % 4 != 0 || m_len > (1 << AW)) ? P_ERR : P_DATA;
            end
            P_DATA: begin
                m_word = m_word | (32'(b) << (8 * (m_cnt % 4)));
                m_sum = 8'((int'(m_sum) + int'(b)) % 256);
                m_cnt++;
                if (m_cnt % 4 == 0) begin
                    exp_q.push_back({AW'(m_cnt - 4), m_word});
                    m_word = 0;
                end
                if (m_cnt == int'(m_len)) m_phase = P_CSUM;
            end
            P_CSUM: m_phase = (b == m_sum) ? P_DONE : P_ERR;
            default: ;
        endcase
    endtask

    task automatic check_status(input string name);
        bit exp_load;
        exp_load = (m_phase == P_LEN) || (m_phase == P_DATA) || (m_phase == P_CSUM);
        check({name, "_err"}, {63'd0, boot_error_o}, {63'd0, m_phase == P_ERR});
        check({name, "_fe"}, {63'd0, fetch_enable_o},
              {63'd0, boot_bypass_i ? fetch_enable_input : (m_phase == P_DONE)});
        check({name, "_load"}, {63'd0, loading_o}, {63'd0, exp_load});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        @(negedge clock);
        uart_rx_input = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx_input = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx_input = stop_ok;
        repeat (CPB) @(negedge clock);
        uart_rx_input = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check_status("byte");
    endtask

    task automatic send_header(input logic [31:0] len);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
    endtask

    function automatic logic [7:0] payload_sum();
        int s = 0;
        foreach (pay_q[i]) s += int'(pay_q[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_frame(input logic [7:0] csum_adj);
        send_header(32'(pay_q.size()));
        foreach (pay_q[i]) send_byte(pay_q[i], 1'b1);
        send_byte(payload_sum() + csum_adj, 1'b1);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic random_payload(input int words);
        pay_q.delete();
        for (int i = 0; i < 4 * words; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic do_reset();
        reset_n_sync = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        reset_n_sync = 1'b1;
        repeat (2) @(negedge clock);
        got_q.delete();
    endtask

    initial begin
        reset_n_sync = 1'b0;
        uart_rx_input = 1'b1;
        boot_bypass_i = 1'b0;
        fetch_enable_input = 1'b0;
        model_reset();
        #1;
        check("rst_req", {63'd0, mem_req_o}, 64'd0);
        check("rst_be", {60'd0, mem_be_o}, 64'hF);
        check("rst_fe", {63'd0, fetch_enable_o}, 64'd0);
        check("rst_err", {63'd0, boot_error_o}, 64'd0);
        check("rst_load", {63'd0, loading_o}, 64'd0);
        do_reset();

        // Good load with the literal image.
        pay_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        check("t1_sum_literal", {56'd0, payload_sum()}, 64'h82);
        send_frame(8'h00);
        check("t1_nwrites", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check("t1_w0", {24'd0, got_q[0]}, {24'd0, 8'h00, 32'h00000013});
            check("t1_w1", {24'd0, got_q[1]}, {24'd0, 8'h04, 32'h0000006F});
        end
        check("t1_fe", {63'd0, fetch_enable_o}, 64'd1);
        check("t1_err", {63'd0, boot_error_o}, 64'd0);
        send_byte(8'hA5, 1'b1);
        check("t1_done_sticky", {63'd0, fetch_enable_o}, 64'd1);

        // Bad checksum, then the corrected resend.
        do_reset();
        send_frame(8'h01);
        check("t2_nwrites", 64'(got_q.size()), 64'd2);
        check("t2_err", {63'd0, boot_error_o}, 64'd1);
        check("t2_fe", {63'd0, fetch_enable_o}, 64'd0);
        send_frame(8'h00);
        check("t2_fe_after", {63'd0, fetch_enable_o}, 64'd1);
        check("t2_err_after", {63'd0, boot_error_o}, 64'd0);

        // Bad lengths: unaligned, zero, and one word past capacity.
        do_reset();
        send_header(32'd6);
        check("t3_len6_err", {63'd0, boot_error_o}, 64'd1);
        send_header(32'd0);
        check("t3_len0_err", {63'd0, boot_error_o}, 64'd1);
        send_header(32'd260);
        check("t3_len260_err", {63'd0, boot_error_o}, 64'd1);
        check("t3_nwrites", 64'(got_q.size()), 64'd0);

        // Noise bytes and a short low glitch ahead of a valid frame.
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        @(negedge clock);
        uart_rx_input = 1'b0;
        repeat (2) @(negedge clock);
        uart_rx_input = 1'b1;
        repeat (4 * CPB) @(negedge clock);
        check_status("t4_glitch");
        random_payload(3);
        send_frame(8'h00);
        check("t4_fe", {63'd0, fetch_enable_o}, 64'd1);

        // Framing error in DATA, then recovery.
        do_reset();
        send_header(32'd8);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        check("t5_err", {63'd0, boot_error_o}, 64'd1);
        check("t5_load", {63'd0, loading_o}, 64'd0);
        random_payload(2);
        send_frame(8'h00);
        check("t5_fe", {63'd0, fetch_enable_o}, 64'd1);

        // Bypass follows the external enable and aborts a load in progress.
        do_reset();
        boot_bypass_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_enable_input = i[0] ? 1'b0 : 1'b1;
            #1;
            check("t6_bypass_fe", {63'd0, fetch_enable_o}, {63'd0, (i % 2) == 0});
            @(negedge clock);
        end
        fetch_enable_input = 1'b0;
        boot_bypass_i = 1'b0;
        send_header(32'd8);
        send_byte(8'h44, 1'b1);
        boot_bypass_i = 1'b1;
        if (m_phase == P_LEN || m_phase == P_DATA || m_phase == P_CSUM) m_phase = P_SYNC;
        repeat (2) @(negedge clock);
        check("t6_bypass_load", {63'd0, loading_o}, 64'd0);
        boot_bypass_i = 1'b0;
        @(negedge clock);

        // Asynchronous reset mid-DATA after one word has been written.
        random_payload(3);
        send_header(32'd12);
        for (int i = 0; i < 5; i++) send_byte(pay_q[i], 1'b1);
        #2;
        reset_n_sync = 1'b0;
        #1;
        check("t6_rst_req", {63'd0, mem_req_o}, 64'd0);
        check("t6_rst_we", {63'd0, mem_we_o}, 64'd0);
        check("t6_rst_be", {60'd0, mem_be_o}, 64'hF);
        check("t6_rst_addr", {56'd0, mem_addr_o}, 64'd0);
        check("t6_rst_wdata", {32'd0, mem_wdata_o}, 64'd0);
        check("t6_rst_load", {63'd0, loading_o}, 64'd0);
        check("t6_rst_err", {63'd0, boot_error_o}, 64'd0);
        check("t6_rst_fe", {63'd0, fetch_enable_o}, 64'd0);
        do_reset();
        random_payload(2);
        send_frame(8'h00);
        check("t6_reload_addr0", 64'(got_q.size() > 0 ? got_q[0][W-1:32] : 8'hFF), 64'd0);
        check("t6_reload_fe", {63'd0, fetch_enable_o}, 64'd1);

        // Randomized images, sometimes with a corrupted checksum first.
        for (int n = 0; n < 6; n++) begin
            do_reset();
            repeat ($urandom_range(0, 20)) @(negedge clock);
            random_payload($urandom_range(1, 6));
            if ($urandom_range(0, 2) == 0) send_frame(8'($urandom_range(1, 255)));
            send_frame(8'h00);
            check("rand_fe", {63'd0, fetch_enable_o}, 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
